// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the RV32I integer ALU: the 4-bit operation select
// type ({funct7[5], funct3}) and the ten opcode constants. Decoder and control
// logic import this same package so the encoding lives in one place.
package alu_pkg;

    localparam int ALU_DATA_W = 32;

    typedef logic [3:0] alu_sel_t;

    localparam alu_sel_t ALU_ADD  = 4'b0000;
    localparam alu_sel_t ALU_SLL  = 4'b0001;
    localparam alu_sel_t ALU_SLT  = 4'b0010;
    localparam alu_sel_t ALU_SLTU = 4'b0011;
    localparam alu_sel_t ALU_XOR  = 4'b0100;
    localparam alu_sel_t ALU_SRL  = 4'b0101;
    localparam alu_sel_t ALU_OR   = 4'b0110;
    localparam alu_sel_t ALU_AND  = 4'b0111;
    localparam alu_sel_t ALU_SUB  = 4'b1000;
    localparam alu_sel_t ALU_SRA  = 4'b1101;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter
// Combinational 32-bit barrel shifter shared by SLL, SRL and SRA.
// Left shifts are done by bit-reversing the operand, shifting right with
// zero fill, and reversing the result, so only one log-shifter is needed.
// Ports:
//   i_data   32-bit operand
//   i_shamt  5-bit shift amount
//   i_right  1 = shift right, 0 = shift left
//   i_arith  1 = sign fill on right shifts (ignored for left shifts)
//   o_data   shifted result
module alu_shifter
    import alu_pkg::*;
(
    input  logic [ALU_DATA_W-1:0] i_data,
    input  logic [4:0]            i_shamt,
    input  logic                  i_right,
    input  logic                  i_arith,
    output logic [ALU_DATA_W-1:0] o_data
);

    logic [ALU_DATA_W-1:0] w_in_rev;
    logic [ALU_DATA_W-1:0] w_shifted;
    logic [ALU_DATA_W-1:0] w_out_rev;
    logic                  w_fill;

    genvar gi;
    generate
        for (gi = 0; gi < ALU_DATA_W; gi++) begin : g_rev
            assign w_in_rev[gi]  = i_data[ALU_DATA_W-1-gi];
            assign w_out_rev[gi] = w_shifted[ALU_DATA_W-1-gi];
        end
    endgenerate

    // Sign fill only applies to arithmetic right shifts.
    assign w_fill = i_right & i_arith & i_data[ALU_DATA_W-1];

    // Five log stages: stage k shifts right by 2^k when amount bit k is set.
    always_comb begin
        w_shifted = i_right ? i_data : w_in_rev;
        for (int k = 0; k < 5; k++) begin
            if (i_shamt[k]) begin
                w_shifted = (w_shifted >> (32'd1 << k))
                          | (w_fill ? ~({ALU_DATA_W{1'b1}} >> (32'd1 << k))
                                    : {ALU_DATA_W{1'b0}});
            end
        end
    end

    assign o_data = i_right ? w_shifted : w_out_rev;

endmodule

// File: rtl/alu.sv
// alu
// RV32I execute-stage integer ALU with a registered result (1-cycle latency,
// one operation per cycle, no handshake).
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset; clears out to 0
//   inputA  operand A (rs1 or PC)
//   inputB  operand B (rs2 or immediate); [4:0] is the shift amount
//   ALUSel  operation select {funct7[5], funct3}; unused codes give 0
//   out     registered result
module alu
    import alu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ALU_DATA_W-1:0] inputA,
    input  logic [ALU_DATA_W-1:0] inputB,
    input  alu_sel_t              ALUSel,
    output logic [ALU_DATA_W-1:0] out
);

    logic                  w_do_sub;
    logic [ALU_DATA_W-1:0] w_add_b;
    logic [ALU_DATA_W-1:0] w_sum;
    logic                  w_carry;
    logic                  w_lt;
    logic                  w_ltu;
    logic [ALU_DATA_W-1:0] w_shift;
    logic [ALU_DATA_W-1:0] w_result;
    logic [ALU_DATA_W-1:0] r_out;

    // One adder serves ADD, SUB and both compares; compares need A - B.
    assign w_do_sub = (ALUSel == ALU_SUB) || (ALUSel == ALU_SLT) || (ALUSel == ALU_SLTU);
    assign w_add_b  = inputB ^ {ALU_DATA_W{w_do_sub}};
    assign {w_carry, w_sum} = {1'b0, inputA} + {1'b0, w_add_b}
                            + {{ALU_DATA_W{1'b0}}, w_do_sub};

    // Unsigned: no carry out of A + ~B + 1 means a borrow, i.e. A < B.
    assign w_ltu = ~w_carry;
    // Signed: differing signs decide directly, so the sign of the difference
    // is only trusted when it cannot have overflowed.
    assign w_lt  = (inputA[ALU_DATA_W-1] ^ inputB[ALU_DATA_W-1])
                 ? inputA[ALU_DATA_W-1] : w_sum[ALU_DATA_W-1];

    // funct3[2] selects right shifts (101); funct7[5] selects arithmetic.
    alu_shifter u_shifter (
        .i_data  (inputA),
        .i_shamt (inputB[4:0]),
        .i_right (ALUSel[2]),
        .i_arith (ALUSel[3]),
        .o_data  (w_shift)
    );

    always_comb begin
        w_result = '0;
        case (ALUSel)
            ALU_ADD,
            ALU_SUB:  w_result = w_sum;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  w_result = w_shift;
            ALU_SLT:  w_result = {{(ALU_DATA_W-1){1'b0}}, w_lt};
            ALU_SLTU: w_result = {{(ALU_DATA_W-1){1'b0}}, w_ltu};
            ALU_XOR:  w_result = inputA ^ inputB;
            ALU_OR:   w_result = inputA | inputB;
            ALU_AND:  w_result = inputA & inputB;
            default:  w_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_result;
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_alu.sv
module tb_alu;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] inputA;
    logic [31:0] inputB;
    alu_sel_t    ALUSel;
    logic [31:0] out;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t sb[$];

    alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .inputA (inputA),
        .inputB (inputB),
        .ALUSel (ALUSel),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end else begin
            $display("ok   %s out=0x%08h", name, act);
        end
    endtask

    // Monitor: the result of the vector pushed during a cycle is visible just
    // after the following rising edge.
    initial begin
        item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                it = sb.pop_front();
                check(it.name, out, it.exp);
            end
        end
    end

    // Called at edge+2: drive inputs, queue expectation, move to next edge+2.
    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input alu_sel_t sel, input logic [31:0] exp,
                         input string name);
        item_t it;
        inputA = a;
        inputB = b;
        ALUSel = sel;
        it.exp  = exp;
        it.name = name;
        sb.push_back(it);
        @(posedge clk);
        #2;
    endtask

    initial begin
        int wait_cycles;
        checks   = 0;
        failures = 0;
        rst_n  = 1'b0;
        inputA = 32'h1234_5678;
        inputB = 32'h0000_0011;
        ALUSel = ALU_ADD;

        // Reset held with arbitrary inputs, across a clock edge
        #2;
        check("reset_async", out, 32'h0);
        @(posedge clk);
        #2;
        check("reset_hold", out, 32'h0);
        rst_n = 1'b1;
        drive(32'd5, 32'd3, ALU_ADD, 32'd8, "release_add");

        // One op per cycle sweep
        drive(32'hFFFF_FFFE, 32'h2, ALU_ADD,  32'h0000_0000, "sweep_add");
        drive(32'hFFFF_FFFE, 32'h2, ALU_SUB,  32'hFFFF_FFFC, "sweep_sub");
        drive(32'hFFFF_FFFE, 32'h2, ALU_SLL,  32'hFFFF_FFF8, "sweep_sll");
        drive(32'hFFFF_FFFE, 32'h2, ALU_SLT,  32'h0000_0001, "sweep_slt");
        drive(32'hFFFF_FFFE, 32'h2, ALU_SLTU, 32'h0000_0000, "sweep_sltu");
        drive(32'hFFFF_FFFE, 32'h2, ALU_XOR,  32'hFFFF_FFFC, "sweep_xor");
        drive(32'hFFFF_FFFE, 32'h2, ALU_SRL,  32'h3FFF_FFFF, "sweep_srl");
        drive(32'hFFFF_FFFE, 32'h2, ALU_SRA,  32'hFFFF_FFFF, "sweep_sra");
        drive(32'hFFFF_FFFE, 32'h2, ALU_OR,   32'hFFFF_FFFE, "sweep_or");
        drive(32'hFFFF_FFFE, 32'h2, ALU_AND,  32'h0000_0002, "sweep_and");

        // Signed compare edges
        drive(32'h8000_0000, 32'h1,         ALU_SLT,  32'h1, "slt_minint");
        drive(32'h8000_0000, 32'h1,         ALU_SLTU, 32'h0, "sltu_minint");
        drive(32'h7FFF_FFFF, 32'h8000_0000, ALU_SLT,  32'h0, "slt_maxint");
        drive(32'h7FFF_FFFF, 32'h8000_0000, ALU_SLTU, 32'h1, "sltu_maxint");
        drive(32'h1234_5678, 32'h1234_5678, ALU_SLT,  32'h0, "slt_equal");
        drive(32'h1234_5678, 32'h1234_5678, ALU_SLTU, 32'h0, "sltu_equal");

        // Shift bounds; upper B bits ignored
        drive(32'h8000_0001, 32'h0,  ALU_SLL, 32'h8000_0001, "sll_0");
        drive(32'h8000_0001, 32'h0,  ALU_SRL, 32'h8000_0001, "srl_0");
        drive(32'h8000_0001, 32'h0,  ALU_SRA, 32'h8000_0001, "sra_0");
        drive(32'h8000_0001, 32'h3F, ALU_SLL, 32'h8000_0000, "sll_31");
        drive(32'h8000_0001, 32'h3F, ALU_SRL, 32'h0000_0001, "srl_31");
        drive(32'h8000_0001, 32'h3F, ALU_SRA, 32'hFFFF_FFFF, "sra_31");
        drive(32'h8000_0001, 32'hFFFF_FFE4, ALU_SRA, 32'hF800_0000, "sra_4_hib");
        drive(32'h0000_00F1, 32'h0000_0108, ALU_SLL, 32'h0000_F100, "sll_8_hib");

        // Wrap and unused codes
        drive(32'hFFFF_FFFF, 32'h1, ALU_ADD, 32'h0000_0000, "add_wrap");
        drive(32'h0,         32'h1, ALU_SUB, 32'hFFFF_FFFF, "sub_wrap");
        drive(32'hDEAD_BEEF, 32'h5, 4'b1111, 32'h0, "unused_1111");
        drive(32'hDEAD_BEEF, 32'h5, 4'b1001, 32'h0, "unused_1001");
        drive(32'hDEAD_BEEF, 32'h5, 4'b1010, 32'h0, "unused_1010");
        drive(32'hDEAD_BEEF, 32'h5, 4'b1011, 32'h0, "unused_1011");
        drive(32'hDEAD_BEEF, 32'h5, 4'b1100, 32'h0, "unused_1100");
        drive(32'hDEAD_BEEF, 32'h5, 4'b1110, 32'h0, "unused_1110");

        // Reset mid-stream: second ADD is in flight when reset hits
        drive(32'd1, 32'd2, ALU_ADD, 32'd3, "mid_add1");
        begin
            item_t it;
            inputA = 32'd10;
            inputB = 32'd20;
            ALUSel = ALU_ADD;
            it.exp  = 32'd30;
            it.name = "mid_add2";
            sb.push_back(it);
            #3;
            rst_n = 1'b0;
            void'(sb.pop_back());   // in-flight result is lost
            #1;
            check("mid_reset_drop", out, 32'h0);
            @(posedge clk);
            #1;
            check("mid_reset_hold", out, 32'h0);
            #1;
            rst_n = 1'b1;
        end
        drive(32'd7, 32'd8, ALU_ADD, 32'd15, "resume_add1");
        drive(32'd100, 32'd1, ALU_SUB, 32'd99, "resume_sub");

        // Drain the scoreboard, bounded
        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
